agen_lsu_skid_buffer: RTL and testbench

//  Registered decoupling stage between the address-generation ALU and the load/store unit.

---
 rtl/agen_lsu_skid_buffer.sv | 90 +++++++++
 tb/tb_agen_lsu_skid_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/agen_lsu_skid_buffer.sv
// agen_lsu_skid_buffer: 2-entry registered skid buffer between AGEN and LSU with
// misalignment flagging and branch-mask based squash/compaction.
module agen_lsu_skid_buffer #(
  parameter int DATA_W  = 32,
  parameter int SIZE_W  = 2,
  parameter int LSQ_W   = 5,
  parameter int BMASK_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [DATA_W-1:0]  address_i,
  input  logic [SIZE_W-1:0]  ldstSize_i,
  input  logic               isLoad_i,
  input  logic [LSQ_W-1:0]   lsqId_i,
  input  logic [BMASK_W-1:0] bMask_i,
  input  logic               flush_i,
  input  logic               brValid_i,
  input  logic               brMispred_i,
  input  logic [BMASK_W-1:0] brTag_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DATA_W-1:0]  address_o,
  output logic [SIZE_W-1:0]  ldstSize_o,
  output logic               isLoad_o,
  output logic [LSQ_W-1:0]   lsqId_o,
  output logic [BMASK_W-1:0] bMask_o,
  output logic               misaligned_o
);
  localparam logic [SIZE_W-1:0] LDST_HALF_WORD = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] LDST_WORD      = SIZE_W'(2);
  typedef struct packed {
    logic [DATA_W-1:0]  addr;
    logic [SIZE_W-1:0]  size;
    logic               ld;
    logic [LSQ_W-1:0]   lsq;
    logic [BMASK_W-1:0] mask;
    logic               mis;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t             r_state, w_next;
  entry_t             r_e0, r_e1, w_e0, w_e1, w_in, w_n0, w_n1;
  logic [BMASK_W-1:0] w_clr;
  logic               w_mispred, w_kill_in, w_push, w_pop, w_keep0, w_keep1;
  logic [1:0]         w_cnt;
  always_comb begin
    w_mispred = brValid_i & brMispred_i;
    w_clr     = (brValid_i & ~brMispred_i) ? brTag_i : '0;
    w_in      = '{addr: address_i, size: ldstSize_i, ld: isLoad_i, lsq: lsqId_i,
                  mask: bMask_i & ~w_clr,
                  mis: (ldstSize_i == LDST_HALF_WORD & address_i[0]) |
                       (ldstSize_i == LDST_WORD & |address_i[1:0])};
    w_kill_in = w_mispred & |(bMask_i & brTag_i);
    w_push    = valid_i & ready_o & ~w_kill_in;
    w_pop     = valid_o & ready_i;
    w_e0      = r_e0;
    w_e0.mask = r_e0.mask & ~w_clr;
    w_e1      = r_e1;
    w_e1.mask = r_e1.mask & ~w_clr;
    // a popped head has left for the LSU, so a same-cycle kill cannot touch it
    w_keep0   = (r_state != EMPTY) & ~w_pop & ~(w_mispred & |(r_e0.mask & brTag_i));
    w_keep1   = (r_state == FULL) & ~(w_mispred & |(r_e1.mask & brTag_i));
    w_n0      = w_keep0 ? w_e0 : w_keep1 ? w_e1 : w_in;
    w_n1      = (w_keep0 & w_keep1) ? w_e1 : w_in;
    w_cnt     = 2'(w_keep0) + 2'(w_keep1) + 2'(w_push);
    w_next    = flush_i ? EMPTY : w_cnt == 2'd0 ? EMPTY : w_cnt == 2'd1 ? ONE : FULL;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_e0    <= '0;
      r_e1    <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      r_state <= w_next;
      r_e0    <= w_n0;
      r_e1    <= w_n1;
      valid_o <= w_next != EMPTY;
      ready_o <= w_next != FULL;
    end
  end
  assign address_o    = r_e0.addr;
  assign ldstSize_o   = r_e0.size;
  assign isLoad_o     = r_e0.ld;
  assign lsqId_o      = r_e0.lsq;
  assign bMask_o      = r_e0.mask;
  assign misaligned_o = r_e0.mis;
endmodule

// File: tb/tb_agen_lsu_skid_buffer.sv
// tb_agen_lsu_skid_buffer: queue-model scoreboard bench for agen_lsu_skid_buffer.
module tb_agen_lsu_skid_buffer;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        valid_i = 0, ready_o, isLoad_i = 0, flush_i = 0, brValid_i = 0, brMispred_i = 0;
  logic [31:0] address_i = '0, address_o;
  logic [1:0]  ldstSize_i = '0, ldstSize_o;
  logic [4:0]  lsqId_i = '0, lsqId_o;
  logic [3:0]  bMask_i = '0, brTag_i = '0, bMask_o;
  logic        valid_o, ready_i = 0, isLoad_o, misaligned_o;
  int          n_checks = 0, n_errors = 0;
  bit          acc;
  typedef struct {
    logic [31:0] a;
    logic [1:0]  s;
    logic        l;
    logic [4:0]  q;
    logic [3:0]  m;
  } ent_t;
  ent_t mq[$];
  always #5 clk = ~clk;
  agen_lsu_skid_buffer dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .address_i(address_i), .ldstSize_i(ldstSize_i), .isLoad_i(isLoad_i),
    .lsqId_i(lsqId_i), .bMask_i(bMask_i), .flush_i(flush_i), .brValid_i(brValid_i),
    .brMispred_i(brMispred_i), .brTag_i(brTag_i), .valid_o(valid_o), .ready_i(ready_i),
    .address_o(address_o), .ldstSize_o(ldstSize_o), .isLoad_o(isLoad_o),
    .lsqId_o(lsqId_o), .bMask_o(bMask_o), .misaligned_o(misaligned_o)
  );
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic mis_of(ent_t e);
    return (e.s == 2'd1 && e.a[0]) || (e.s == 2'd2 && e.a[1:0] != 2'b00);
  endfunction
  task automatic compare();
    check("valid_o", valid_o, mq.size() != 0);
    check("ready_o", ready_o, mq.size() < 2);
    if (mq.size() != 0) begin
      check("address_o", address_o, mq[0].a);
      check("ldstSize_o", ldstSize_o, mq[0].s);
      check("isLoad_o", isLoad_o, mq[0].l);
      check("lsqId_o", lsqId_o, mq[0].q);
      check("bMask_o", bMask_o, mq[0].m);
      check("misaligned_o", misaligned_o, mis_of(mq[0]));
    end
  endtask
  task automatic cycle();
    bit   rdy, pop, kin;
    ent_t e;
    ent_t nq[$];
    rdy = mq.size() < 2;
    pop = mq.size() > 0 && ready_i;
    kin = brValid_i && brMispred_i && (bMask_i & brTag_i) != 0;
    acc = 0;
    @(posedge clk);
    if (flush_i) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (brValid_i) begin
        nq = {};
        foreach (mq[i]) begin
          e = mq[i];
          if (!brMispred_i) begin
            e.m &= ~brTag_i;
            nq.push_back(e);
          end else if ((e.m & brTag_i) == 0) nq.push_back(e);
        end
        mq = nq;
      end
      if (valid_i && rdy && !kin) begin
        e = '{address_i, ldstSize_i, isLoad_i, lsqId_i,
              (brValid_i && !brMispred_i) ? (bMask_i & ~brTag_i) : bMask_i};
        mq.push_back(e);
        acc = 1;
      end
    end
    #1 compare();
  endtask
  task automatic set_in(logic [31:0] a, logic [1:0] s, logic l, logic [4:0] q, logic [3:0] m);
    valid_i = 1; address_i = a; ldstSize_i = s; isLoad_i = l; lsqId_i = q; bMask_i = m;
  endtask
  task automatic push_hold(logic [31:0] a, logic [1:0] s, logic l, logic [4:0] q, logic [3:0] m);
    set_in(a, s, l, q, m);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) check("push_timeout", acc, 1);
    valid_i = 0;
  endtask
  task automatic idle(int n);
    valid_i = 0;
    repeat (n) cycle();
  endtask
  task automatic branch(logic mis, logic [3:0] tag);
    brValid_i = 1; brMispred_i = mis; brTag_i = tag;
    cycle();
    brValid_i = 0; brMispred_i = 0; brTag_i = '0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_addr", address_o, 0);
    check("rst_mask", bMask_o, 0);
    @(negedge clk) reset_n = 1;
    ready_i = 1;
    push_hold(32'h1000, 2'd2, 1, 5'd1, 4'h0);
    check("t1_valid", valid_o, 1);
    check("t1_addr", address_o, 32'h1000);
    check("t1_mis", misaligned_o, 0);
    idle(2);
    ready_i = 0;
    push_hold(32'h2000, 2'd2, 1, 5'd2, 4'h0);
    push_hold(32'h2004, 2'd2, 0, 5'd3, 4'h0);
    check("t2_ready_low", ready_o, 0);
    set_in(32'h2008, 2'd2, 1, 5'd4, 4'h0);
    repeat (3) begin
      cycle();
      check("t2_held", acc, 0);
    end
    ready_i = 1;
    push_hold(32'h2008, 2'd2, 1, 5'd4, 4'h0);
    idle(4);
    push_hold(32'h1001, 2'd1, 1, 5'd5, 4'h0);
    check("t3_half_mis", misaligned_o, 1);
    push_hold(32'h1002, 2'd2, 1, 5'd6, 4'h0);
    check("t3_word_mis", misaligned_o, 1);
    push_hold(32'h1003, 2'd0, 1, 5'd7, 4'h0);
    check("t3_byte_mis", misaligned_o, 0);
    idle(3);
    ready_i = 0;
    push_hold(32'h3000, 2'd2, 1, 5'd8, 4'b0001);
    push_hold(32'h3004, 2'd2, 1, 5'd9, 4'b0010);
    branch(1, 4'b0010);
    check("t4_valid", valid_o, 1);
    check("t4_ready", ready_o, 1);
    check("t4_addr", address_o, 32'h3000);
    ready_i = 1;
    idle(3);
    ready_i = 0;
    push_hold(32'h4000, 2'd2, 1, 5'd10, 4'b0001);
    push_hold(32'h4004, 2'd2, 0, 5'd11, 4'b0000);
    branch(1, 4'b0001);
    check("t5_valid", valid_o, 1);
    check("t5_addr", address_o, 32'h4004);
    ready_i = 1;
    idle(3);
    ready_i = 0;
    push_hold(32'h5000, 2'd2, 1, 5'd12, 4'b0110);
    push_hold(32'h5004, 2'd2, 1, 5'd13, 4'b0110);
    branch(0, 4'b0100);
    check("t6_mask", bMask_o, 4'b0010);
    set_in(32'h6000, 2'd2, 1, 5'd14, 4'h0);
    flush_i = 1;
    cycle();
    flush_i = 0;
    valid_i = 0;
    check("t6_flush_valid", valid_o, 0);
    check("t6_flush_ready", ready_o, 1);
    push_hold(32'h7000, 2'd2, 1, 5'd15, 4'h0);
    #2 reset_n = 0;
    #1;
    mq.delete();
    check("arst_valid", valid_o, 0);
    check("arst_ready", ready_o, 1);
    check("arst_addr", address_o, 0);
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 400; i++) begin
      valid_i     = $urandom_range(0, 1);
      address_i   = $urandom;
      ldstSize_i  = 2'($urandom_range(0, 3));
      isLoad_i    = $urandom_range(0, 1);
      lsqId_i     = 5'($urandom);
      bMask_i     = 4'($urandom);
      ready_i     = $urandom_range(0, 2) != 0;
      brValid_i   = $urandom_range(0, 3) == 0;
      brMispred_i = $urandom_range(0, 1);
      brTag_i     = 4'(1 << $urandom_range(0, 3));
      flush_i     = $urandom_range(0, 29) == 0;
      cycle();
    end
    brValid_i = 0; flush_i = 0;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
